// File: rtl/hnf_rxdat.sv
// hnf_rxdat: HN-F RXDAT link-layer receiver.
// Issues L-credits on the CHI RXDAT channel, accepts data flits against them
// and queues them in order (DATPOSQ). The oldest entry is presented on a
// valid/ready interface. DataLCrdReturn flits (opcode 0) only return a credit.
// Optional build macro HNF_RXDAT_PROT_CHK_EN adds a sticky protocol-error flag
// and a simulation assertion; without it rxdat_prot_err is tied low.
// The opcode is taken from RXDATFLIT[OPC_LSB +: OPC_W].
module hnf_rxdat #(
  parameter int DEPTH    = 8,   // 2..15
  parameter int MAX_LCRD = 15,
  parameter int FLIT_W   = 32,
  parameter int OPC_LSB  = 0,
  parameter int OPC_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] RXDATFLIT,
  input  logic              RXDATFLITV,
  input  logic              RXDATFLITPEND,
  output logic              RXDATLCRDV,
  output logic [FLIT_W-1:0] rxdat_posq_first_entry,
  output logic              rxdat_posq_first_entry_valid,
  input  logic              rxdat_posq_first_entry_ready,
  output logic              rxdat_prot_err
);

  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int LCRD_W = $clog2(MAX_LCRD + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SUM_W  = 8;

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [LCRD_W-1:0] lcrd_q, lcrd_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              grant_q, grant_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic             is_data;
  logic             consume;
  logic             push;
  logic             pop;
  logic             full;
  logic             overflow;
  logic [SUM_W-1:0] cap_sum;
  logic [SUM_W-1:0] lcrd_sum;

  // The early-flit hint carries no information this receiver needs.
  logic unused_pend;
  assign unused_pend = RXDATFLITPEND;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode, counter updates and next credit decision.
  always_comb begin
    is_data  = RXDATFLIT[OPC_LSB +: OPC_W] != '0;
    consume  = RXDATFLITV && (lcrd_q != '0);
    pop      = rxdat_posq_first_entry_valid && rxdat_posq_first_entry_ready;
    full     = occ_q == OCC_W'(DEPTH);
    // Credit accounting should make this impossible; never overwrite the head.
    overflow = consume && is_data && full && !pop;
    push     = consume && is_data && !overflow;

    lcrd_d   = lcrd_q + LCRD_W'(grant_q) - LCRD_W'(consume);
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Registered occupancy: a slot freed by a pop backs a credit one cycle later.
    cap_sum  = SUM_W'(occ_q) + SUM_W'(lcrd_q) + SUM_W'(grant_q);
    lcrd_sum = SUM_W'(lcrd_q) + SUM_W'(grant_q);
    grant_d  = (cap_sum < SUM_W'(DEPTH)) && (lcrd_sum < SUM_W'(MAX_LCRD));
  end

  // Control state; everything returns to idle on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q    <= '0;
      lcrd_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      grant_q  <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      lcrd_q   <= lcrd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Queue storage is data only and is not reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= RXDATFLIT;
  end

  assign RXDATLCRDV                   = grant_q;
  assign rxdat_posq_first_entry       = mem_q[rd_ptr_q];
  assign rxdat_posq_first_entry_valid = occ_q != '0;

`ifdef HNF_RXDAT_PROT_CHK_EN
  logic illegal_flit;
  logic prot_err_q, prot_err_d;

  // A flit with no credit outstanding, or a push into a full queue, is sticky.
  always_comb begin
    illegal_flit = RXDATFLITV && (lcrd_q == '0);
    prot_err_d   = prot_err_q || illegal_flit || overflow;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prot_err_q <= 1'b0;
    else        prot_err_q <= prot_err_d;
  end

  assign rxdat_prot_err = prot_err_q;

  a_no_prot_viol: assert property (@(posedge clock) disable iff (!reset)
                                   !(illegal_flit || overflow))
    else $error("hnf_rxdat: RXDAT protocol violation");
`else
  assign rxdat_prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_hnf_rxdat.sv
module tb_hnf_rxdat;

  logic        clock;
  logic        reset;
  logic [31:0] flit;
  logic        flitv;
  logic        pend;
  logic        lcrdv;
  logic [31:0] head;
  logic        head_v;
  logic        rdy;
  logic        prot_err;

  hnf_rxdat dut (
    .clock                        (clock),
    .reset                        (reset),
    .RXDATFLIT                    (flit),
    .RXDATFLITV                   (flitv),
    .RXDATFLITPEND                (pend),
    .RXDATLCRDV                   (lcrdv),
    .rxdat_posq_first_entry       (head),
    .rxdat_posq_first_entry_valid (head_v),
    .rxdat_posq_first_entry_ready (rdy),
    .rxdat_prot_err               (prot_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef HNF_RXDAT_PROT_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [31:0] RET_FLIT = 32'hDEAD_BE00;  // opcode 0: DataLCrdReturn
  localparam logic [31:0] BAD_FLIT = 32'hBAD0_0004;

  typedef struct {
    logic        v;
    logic [31:0] f;
    logic        r;
    logic        crd;
    logic        val;
    logic [31:0] hd;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   grants;

  function automatic logic [31:0] fl(input int k);
    return 32'hD000_0004 | (32'(k) << 8);
  endfunction

  function automatic void add(input logic v, input logic [31:0] f, input logic r,
                              input logic crd, input logic val, input logic [31:0] hd);
    vec_t e;
    e.v = v; e.f = f; e.r = r; e.crd = crd; e.val = val; e.hd = hd;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] f, input logic r);
    flitv = v;
    flit  = f;
    pend  = v;
    rdy   = r;
  endtask

  initial begin
    // Per-cycle table: outputs checked at the negedge, then inputs for that cycle applied.
    add(0, 0, 0, 0, 0, 0);                                    // 0: reset release
    for (int r = 1; r <= 8; r++) add(0, 0, 0, 1, 0, 0);       // 1..8 grants
    add(0, 0, 0, 0, 0, 0);                                    // 9
    for (int k = 0; k < 8; k++) add(1, fl(k), 0, 0, k > 0, fl(0)); // 10..17 fill
    add(0, 0, 1, 0, 1, fl(0));                                // 18 pop
    add(0, 0, 1, 0, 1, fl(1));                                // 19 pop
    add(0, 0, 1, 1, 1, fl(2));                                // 20 pop
    add(0, 0, 0, 1, 1, fl(3));                                // 21
    add(0, 0, 0, 1, 1, fl(3));                                // 22
    add(1, fl(8), 0, 0, 1, fl(3));                            // 23 wr_ptr wrap
    add(0, 0, 1, 0, 1, fl(3));                                // 24 drain
    add(0, 0, 1, 0, 1, fl(4));                                // 25
    for (int k = 5; k <= 8; k++) add(0, 0, 1, 1, 1, fl(k));   // 26..29
    add(0, 0, 1, 1, 0, 0);                                    // 30 ready while empty
    add(0, 0, 0, 1, 0, 0);                                    // 31
    add(1, fl(9), 0, 0, 0, 0);                                // 32
    for (int k = 10; k <= 15; k++) add(1, fl(k), 0, 0, 1, fl(9)); // 33..38
    add(1, RET_FLIT, 0, 0, 1, fl(9));                         // 39 credit return
    add(0, 0, 0, 0, 1, fl(9));                                // 40
    add(0, 0, 0, 1, 1, fl(9));                                // 41 re-grant
    add(0, 0, 1, 0, 1, fl(9));                                // 42 drain
    add(0, 0, 1, 0, 1, fl(10));                               // 43
    for (int k = 11; k <= 15; k++) add(0, 0, 1, 1, 1, fl(k)); // 44..48
    add(0, 0, 0, 1, 0, 0);                                    // 49

    drive(0, 0, 0);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_crd", 32'(lcrdv), 0);
    check("reset_valid", 32'(head_v), 0);
    check("reset_err", 32'(prot_err), 0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clock);
      check($sformatf("row%0d_crd", i), 32'(lcrdv), 32'(tbl[i].crd));
      check($sformatf("row%0d_valid", i), 32'(head_v), 32'(tbl[i].val));
      if (tbl[i].val) check($sformatf("row%0d_head", i), head, tbl[i].hd);
      drive(tbl[i].v, tbl[i].f, tbl[i].r);
    end

    // Illegal flit with no credit outstanding: fill the queue so lcrd_out is 0.
    repeat (4) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      drive(1, fl(32 + k), 0);
      @(negedge clock);
    end
    drive(0, 0, 0);
    @(negedge clock);
    check("full_crd", 32'(lcrdv), 0);
    check("full_head", head, fl(32));
    drive(1, BAD_FLIT, 0);
    @(negedge clock);
    drive(0, 0, 0);
    check("illegal_valid", 32'(head_v), 1);
    check("illegal_head", head, fl(32));
    check("illegal_err", 32'(prot_err), 32'(EXP_ERR));
    @(negedge clock);
    check("illegal_crd", 32'(lcrdv), 0);

    grants = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d_valid", k), 32'(head_v), 1);
      check($sformatf("drain%0d_head", k), head, fl(32 + k));
      drive(0, 0, 1);
      @(negedge clock);
      grants += int'(lcrdv);
    end
    drive(0, 0, 0);
    check("drain_empty", 32'(head_v), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      grants += int'(lcrdv);
    end
    check("drain_grants", 32'(grants), 8);
    check("drain_crd_idle", 32'(lcrdv), 0);
    check("err_sticky", 32'(prot_err), 32'(EXP_ERR));

    // Reset mid-stream with 4 queued and 4 credits outstanding.
    for (int k = 0; k < 4; k++) begin
      drive(1, fl(48 + k), 0);
      @(negedge clock);
    end
    drive(0, 0, 0);
    @(negedge clock);
    check("pre_rst_valid", 32'(head_v), 1);
    check("pre_rst_head", head, fl(48));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_crd", 32'(lcrdv), 0);
    check("mid_rst_valid", 32'(head_v), 0);
    check("mid_rst_err", 32'(prot_err), 0);
    @(negedge clock);
    reset = 1'b1;
    check("rerel_crd0", 32'(lcrdv), 0);
    for (int r = 1; r <= 8; r++) begin
      @(negedge clock);
      check($sformatf("rerel_crd%0d", r), 32'(lcrdv), 1);
    end
    @(negedge clock);
    check("rerel_crd9", 32'(lcrdv), 0);
    drive(1, fl(60), 0);
    @(negedge clock);
    drive(0, 0, 1);
    check("rerel_valid", 32'(head_v), 1);
    check("rerel_head", head, fl(60));
    @(negedge clock);
    drive(0, 0, 0);
    check("rerel_empty", 32'(head_v), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
